// File: rtl/dwt_pkg.sv
// Shared types and helpers for the DWT frame packer.
package dwt_pkg;

  localparam int COEF_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } bank_state_t;

  // Mallat offset of the first level-l detail coefficient.
  function automatic int detail_base(input int frame_len, input int level);
    return frame_len >> level;
  endfunction

endpackage

// File: rtl/coef_bank.sv
// One frame of coefficient storage: detail and coarse write ports plus a
// combinational read port. The two write addresses never coincide.
module coef_bank #(
  parameter int FRAME_LEN = 16,
  parameter int COEF_W    = 16,
  localparam int AW       = $clog2(FRAME_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_det_we,
  input  logic [AW-1:0]     i_det_addr,
  input  logic [COEF_W-1:0] i_det_dat,
  input  logic              i_crs_we,
  input  logic [AW-1:0]     i_crs_addr,
  input  logic [COEF_W-1:0] i_crs_dat,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [COEF_W-1:0] o_rd_dat
);

  logic [COEF_W-1:0] r_mem [FRAME_LEN];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FRAME_LEN; i++) r_mem[i] <= '0;
    end else begin
      if (i_det_we) r_mem[i_det_addr] <= i_det_dat;
      if (i_crs_we) r_mem[i_crs_addr] <= i_crs_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/dwt_frame_packer.sv
// Collects one multi-level DWT frame into a ping-pong bank in Mallat order
// and drains it over valid/ready; strobes with no free bank are dropped.
module dwt_frame_packer
  import dwt_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int LEVELS    = 2,
  parameter int COEF_W    = dwt_pkg::COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COEF_W-1:0] detail_in,
  input  logic              detail_valid,
  input  logic [COEF_W-1:0] coarse_in,
  input  logic              coarse_valid,
  output logic [COEF_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int AW       = $clog2(FRAME_LEN);
  localparam int CW       = AW + 1;
  localparam int C        = FRAME_LEN >> LEVELS;
  localparam int TOTAL    = FRAME_LEN - C;
  localparam int CRS_KEEP = FRAME_LEN - 2 * C;

  bank_state_t       r_state     [2];
  bank_state_t       w_state_nxt [2];
  logic              r_col;
  logic              r_rd_bank;
  logic [CW-1:0]     r_det_cnt;
  logic [CW-1:0]     r_crs_cnt;
  logic [AW-1:0]     r_rd_ptr;
  logic              r_ovf;

  logic              w_col_ok;
  logic              w_det_we;
  logic              w_crs_we;
  logic              w_drop;
  logic              w_done;
  logic [CW-1:0]     w_det_nxt;
  logic [CW-1:0]     w_crs_nxt;
  int                w_det_lvl;
  int                w_det_off;
  logic [AW-1:0]     w_det_addr;
  logic [AW-1:0]     w_crs_addr;
  logic              w_crs_store;
  logic              w_acc;
  logic              w_last_acc;
  logic [COEF_W-1:0] w_rd_dat [2];

  assign w_col_ok  = (r_state[r_col] == EMPTY) || (r_state[r_col] == COLLECT);
  assign w_det_we  = detail_valid && w_col_ok && (r_det_cnt < CW'(TOTAL));
  assign w_crs_we  = coarse_valid && w_col_ok && (r_crs_cnt < CW'(TOTAL));
  assign w_drop    = (detail_valid || coarse_valid) && !w_col_ok;
  assign w_det_nxt = r_det_cnt + CW'(w_det_we);
  assign w_crs_nxt = r_crs_cnt + CW'(w_crs_we);
  assign w_done    = (w_det_we || w_crs_we) &&
                     (w_det_nxt == CW'(TOTAL)) && (w_crs_nxt == CW'(TOTAL));

  // Level l starts after FRAME_LEN - 2*(FRAME_LEN>>l) details of shallower levels.
  always_comb begin
    w_det_lvl = 1;
    for (int l = 2; l <= LEVELS; l++) begin
      if (int'(r_det_cnt) >= FRAME_LEN - (FRAME_LEN >> (l - 1))) w_det_lvl = l;
    end
    w_det_off  = int'(r_det_cnt) + 3 * detail_base(FRAME_LEN, w_det_lvl) - FRAME_LEN;
    w_det_addr = AW'(w_det_off);
  end

  // Only the deepest level's coarse coefficients survive into the frame.
  assign w_crs_store = int'(r_crs_cnt) >= CRS_KEEP;
  assign w_crs_addr  = AW'(int'(r_crs_cnt) - CRS_KEEP);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam bit BID = (b == 1);
    coef_bank #(
      .FRAME_LEN (FRAME_LEN),
      .COEF_W    (COEF_W)
    ) u_bank (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_det_we   (w_det_we && (r_col == BID)),
      .i_det_addr (w_det_addr),
      .i_det_dat  (detail_in),
      .i_crs_we   (w_crs_we && w_crs_store && (r_col == BID)),
      .i_crs_addr (w_crs_addr),
      .i_crs_dat  (coarse_in),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_dat   (w_rd_dat[b])
    );
  end

  assign m_valid    = (r_state[r_rd_bank] == FULL) || (r_state[r_rd_bank] == DRAIN);
  assign m_data     = w_rd_dat[r_rd_bank];
  assign m_last     = m_valid && (r_rd_ptr == AW'(FRAME_LEN - 1));
  assign w_acc      = m_valid && m_ready;
  assign w_last_acc = w_acc && m_last;
  assign overflow   = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    for (int b = 0; b < 2; b++) begin
      unique case (r_state[b])
        EMPTY:   if ((r_col == (b == 1)) && (w_det_we || w_crs_we))
                   w_state_nxt[b] = w_done ? FULL : COLLECT;
        COLLECT: if ((r_col == (b == 1)) && w_done) w_state_nxt[b] = FULL;
        FULL:    if (r_rd_bank == (b == 1)) w_state_nxt[b] = DRAIN;
        DRAIN:   if (w_last_acc) w_state_nxt[b] = EMPTY;
        default: w_state_nxt[b] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state[0] <= EMPTY;
      r_state[1] <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col     <= 1'b0;
      r_rd_bank <= 1'b0;
      r_det_cnt <= '0;
      r_crs_cnt <= '0;
      r_rd_ptr  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_done) begin
        r_col     <= ~r_col;
        r_det_cnt <= '0;
        r_crs_cnt <= '0;
      end else begin
        r_det_cnt <= w_det_nxt;
        r_crs_cnt <= w_crs_nxt;
      end
      if (w_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_last_acc) r_rd_bank <= ~r_rd_bank;
      if (w_drop) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwt_frame_packer.sv
// Randomized bench for dwt_frame_packer against a queue-based frame model.
module tb_dwt_frame_packer;

  localparam int N     = 16;
  localparam int L     = 2;
  localparam int W     = 16;
  localparam int C     = N >> L;
  localparam int TOTAL = N - C;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] detail_in = '0;
  logic         detail_valid = 1'b0;
  logic [W-1:0] coarse_in = '0;
  logic         coarse_valid = 1'b0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic         overflow;
  logic         ovf_clr = 1'b0;

  dwt_frame_packer #(.FRAME_LEN(N), .LEVELS(L), .COEF_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .detail_in    (detail_in),
    .detail_valid (detail_valid),
    .coarse_in    (coarse_in),
    .coarse_valid (coarse_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: accepted strobes queue up in arrival order; a complete frame is
  // reordered into Mallat order and appended to the expected output stream.
  logic [W-1:0] exp_q[$];
  bit           exp_last_q[$];
  logic [W-1:0] det_q[$];
  logic [W-1:0] crs_q[$];
  int           pending = 0;
  bit           m_ovf = 1'b0;
  bit           m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete(); exp_last_q.delete(); det_q.delete(); crs_q.delete();
      pending = 0;
      m_ovf   = 1'b0;
    end else begin
      m_acc = (pending < 2);
      if ((detail_valid || coarse_valid) && !m_acc) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (exp_q.size() > 0 && m_ready) begin
        if (exp_last_q[0]) pending--;
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      if (m_acc) begin
        if (detail_valid) det_q.push_back(detail_in);
        if (coarse_valid) crs_q.push_back(coarse_in);
        if (det_q.size() == TOTAL && crs_q.size() == TOTAL) begin
          for (int k = 0; k < C; k++) begin
            exp_q.push_back(crs_q[TOTAL - C + k]);
            exp_last_q.push_back(1'b0);
          end
          for (int l = L; l >= 1; l--)
            for (int k = 0; k < (N >> l); k++) begin
              exp_q.push_back(det_q[N - 2 * (N >> l) + k]);
              exp_last_q.push_back(1'b0);
            end
          exp_last_q[exp_last_q.size() - 1] = 1'b1;
          pending++;
          det_q.delete();
          crs_q.delete();
        end
      end
    end
  end

  logic [W-1:0] log_dat[$];
  bit           log_last[$];
  int           log_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_overflow", overflow, 0);
      check("rst_m_data", m_data, 0);
    end else begin
      check("m_valid", m_valid, exp_q.size() > 0);
      if (m_valid && exp_q.size() > 0) begin
        check("m_data", m_data, exp_q[0]);
        check("m_last", m_last, exp_last_q[0]);
      end else begin
        check("m_last_idle", m_last, 0);
      end
      check("overflow", overflow, m_ovf);
      if (m_valid && m_ready) begin
        log_dat.push_back(m_data);
        log_last.push_back(m_last);
        log_cyc.push_back(cyc);
      end
    end
  end

  int rdy_mode = 0;  // 0 low, 1 high, 2 toggle, 3 random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      2:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_dat.delete(); log_last.delete(); log_cyc.delete();
  endtask

  // mode: 0 detail then coarse, 1 coincident, 2 random mix
  task automatic send_frame(input bit pat, input int mode, input int maxgap);
    logic [W-1:0] d, c;
    bit co;
    for (int l = 1; l <= L; l++)
      for (int k = 0; k < (N >> l); k++) begin
        d  = pat ? W'((l - 1) * 10 + k + 1) : W'($urandom);
        c  = pat ? W'(100 * l + k + 1) : W'($urandom);
        co = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
        if (co) begin
          detail_valid = 1'b1; detail_in = d; coarse_valid = 1'b1; coarse_in = c;
          tick();
        end else begin
          detail_valid = 1'b1; detail_in = d; coarse_valid = 1'b0;
          tick();
          detail_valid = 1'b0; coarse_valid = 1'b1; coarse_in = c;
          tick();
        end
        detail_valid = 1'b0; coarse_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) tick();
      end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
    end
  endtask

  task automatic check_pattern_log(input string tag);
    check({tag, "_beats"}, log_dat.size(), 16);
    if (log_dat.size() == 16) begin
      check({tag, "_beat0"}, log_dat[0], 201);
      check({tag, "_beat3"}, log_dat[3], 204);
      check({tag, "_beat4"}, log_dat[4], 11);
      check({tag, "_beat7"}, log_dat[7], 14);
      check({tag, "_beat8"}, log_dat[8], 1);
      check({tag, "_beat15"}, log_dat[15], 8);
      check({tag, "_last14"}, log_last[14], 0);
      check({tag, "_last15"}, log_last[15], 1);
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // single frame, m_ready high
    clear_log();
    rdy_mode = 1;
    send_frame(1'b1, 0, 0);
    wait_empty(200);
    check_pattern_log("single");

    // backpressure toggling
    clear_log();
    rdy_mode = 2;
    send_frame(1'b1, 0, 0);
    wait_empty(200);
    check_pattern_log("bp");

    // ping-pong: both banks fill, then drain back-to-back
    clear_log();
    rdy_mode = 0;
    send_frame(1'b0, 0, 0);
    send_frame(1'b0, 0, 0);
    @(negedge clk);
    check("pp_valid_held", m_valid, 1);
    rdy_mode = 1;
    tick();
    wait_empty(200);
    check("pp_beats", log_dat.size(), 32);
    if (log_dat.size() == 32) begin
      check("pp_last16", log_last[15], 1);
      check("pp_last32", log_last[31], 1);
      check("pp_span", log_cyc[31] - log_cyc[0], 31);
    end

    // overflow: third frame dropped, clear vs. set priority
    clear_log();
    rdy_mode = 0;
    send_frame(1'b0, 0, 0);
    send_frame(1'b0, 0, 0);
    send_frame(1'b0, 2, 0);
    @(negedge clk);
    check("ovf_set", overflow, 1);
    tick();
    ovf_clr = 1'b1; detail_valid = 1'b1; detail_in = 16'h5a5a;
    tick();
    ovf_clr = 1'b0; detail_valid = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", overflow, 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    rdy_mode = 1;
    tick();
    wait_empty(200);
    check("ovf_beats", log_dat.size(), 32);

    // reset mid-drain
    clear_log();
    rdy_mode = 1;
    send_frame(1'b0, 0, 0);
    n = 0;
    while (log_dat.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    check("rst_beats_before", log_dat.size(), 5);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", m_valid, 0);
    check("midrst_ovf", overflow, 0);
    tick();
    rst = 1'b1;
    tick();
    clear_log();
    send_frame(1'b1, 0, 0);
    wait_empty(200);
    check_pattern_log("after_rst");

    // coincident strobes, random backpressure
    clear_log();
    rdy_mode = 3;
    send_frame(1'b1, 1, 1);
    wait_empty(300);
    check_pattern_log("coinc");

    // random traffic, each frame started only when a bank is free
    rdy_mode = 3;
    for (int f = 0; f < 12; f++) begin
      n = 0;
      while (pending >= 2 && n < 200) begin
        tick();
        n++;
      end
      send_frame(1'b0, 2, 2);
    end
    wait_empty(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
